// File: rtl/bch_pkg.sv
// BCH field constants and GF(2^m) helpers
// shared by the parallel syndrome block.
package bch_pkg;

  localparam int MM = 10;

  typedef enum logic [1:0] {
    C63   = 2'b00,
    C255  = 2'b01,
    C1023 = 2'b10,
    CINV  = 2'b11
  } code_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ODD,
    EVEN
  } state_e;

  function automatic int code_m(input code_e c);
    case (c)
      C63:     return 6;
      C255:    return 8;
      default: return 10;
    endcase
  endfunction

  function automatic int code_n(input code_e c);
    return (1 << code_m(c)) - 1;
  endfunction

  function automatic logic [MM:0] code_poly(input code_e c);
    case (c)
      C63:     return 11'h043;
      C255:    return 11'h11D;
      default: return 11'h409;
    endcase
  endfunction

  function automatic logic [MM-1:0] gf_mulx(
    input logic [MM-1:0] a,
    input code_e         c
  );
    logic [MM:0] r;
    logic        top;
    case (c)
      C63:     top = a[5];
      C255:    top = a[7];
      default: top = a[MM-1];
    endcase
    r = {a, 1'b0};
    if (top) r = r ^ code_poly(c);
    return r[MM-1:0];
  endfunction

  function automatic logic [MM-1:0] gf_mul(
    input logic [MM-1:0] a,
    input logic [MM-1:0] b,
    input code_e         c
  );
    logic [MM-1:0] r;
    logic [MM-1:0] x;
    r = '0;
    x = a;
    for (int i = 0; i < MM; i++) begin
      if (b[i]) r = r ^ x;
      x = gf_mulx(x, c);
    end
    return r;
  endfunction

  function automatic logic [MM-1:0] gf_pow(
    input int    e,
    input code_e c
  );
    logic [MM-1:0] r;
    logic [MM-1:0] b;
    int            x;
    r = MM'(1);
    b = MM'(2);
    x = e % code_n(c);
    for (int i = 0; i < 11; i++) begin
      if (((x >> i) & 1) != 0) r = gf_mul(r, b, c);
      b = gf_mul(b, b, c);
    end
    return r;
  endfunction

  function automatic logic [MM-1:0] step_pow(
    input int    j,
    input int    p,
    input code_e c
  );
    return gf_pow(j * p, c);
  endfunction

  function automatic logic [MM-1:0] lane_pow(
    input int    j,
    input int    k,
    input int    p,
    input code_e c
  );
    return gf_pow(j * (p - 1 - k), c);
  endfunction

  function automatic int code_beats(
    input code_e c,
    input int    p
  );
    return (code_n(c) + p - 1) / p;
  endfunction

  function automatic int code_pad(
    input code_e c,
    input int    p
  );
    return code_beats(c, p) * p - code_n(c);
  endfunction

endpackage

// File: rtl/bch_gf_square.sv
// Field-selectable GF(2^m) squarer used to
// derive even syndromes from odd ones.
module bch_gf_square
  import bch_pkg::*;
(
  input  code_e         code,
  input  logic [MM-1:0] a,
  output logic [MM-1:0] y
);

  // square in the field picked by code
  always_comb begin
    y = gf_mul(a, a, code);
  end

endmodule

// File: rtl/syndrome_par.sv
// P-symbol-per-beat BCH syndrome calculator:
// odd syndromes by Horner, even by squaring.
module syndrome_par
  import bch_pkg::*;
#(
  parameter int P = 8,
  parameter int W = 8,
  parameter int T = 4,
  parameter int M = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_code,
  input  logic             i_valid,
  input  logic             i_first,
  input  logic [P*W-1:0]   i_data,
  output logic             o_ready,
  output logic [2*T*M-1:0] o_synd,
  output logic             o_odd_valid,
  output logic             o_all_valid,
  output logic             o_zero,
  output logic             o_code_err
);

  localparam int CW = 11;

  localparam logic [CW-1:0] B63 =
    CW'(code_beats(C63, P));
  localparam logic [CW-1:0] B255 =
    CW'(code_beats(C255, P));
  localparam logic [CW-1:0] B1023 =
    CW'(code_beats(C1023, P));

  function automatic logic [CW-1:0] beats_of(
    input code_e c
  );
    case (c)
      C63:     return B63;
      C255:    return B255;
      default: return B1023;
    endcase
  endfunction

  state_e                 state;
  state_e                 state_n;
  code_e                  code_q;
  code_e                  code_in;
  code_e                  ucode;
  logic [CW-1:0]          cnt;
  logic [T-1:0][MM-1:0]   odd_q;
  logic [T-1:0][MM-1:0]   even_q;
  logic [T-1:0][MM-1:0]   nxt;
  logic [T-1:0][MM-1:0]   ev;
  logic                   zero_q;
  logic                   err_q;
  logic                   acc;
  logic                   start;
  logic                   bad;
  logic                   step;
  logic [P-1:0]           hb;
  logic [2:0][P-1:0]      hmask;
  logic                   unused;

  assign code_in = code_e'(i_code);
  assign acc     = i_valid && o_ready;
  assign start   = acc && i_first && (code_in != CINV);
  assign bad     = acc && i_first && (code_in == CINV);
  assign step    = acc && !i_first && (state == LOAD);
  assign ucode   = i_first ? code_in : code_q;
  assign unused  = ^i_data;

  // hard decision is the MSB of each lane
  always_comb begin
    hb = '0;
    for (int k = 0; k < P; k++) begin
      hb[k] = i_data[(P-k)*W-1];
    end
  end

  // leading pad lanes of a first beat are zeroed
  for (genvar c = 0; c < 3; c++) begin : g_mask
    localparam int PADC = code_pad(code_e'(c), P);
    for (genvar k = 0; k < P; k++) begin : g_lane
      if (k < PADC) begin : g_pad
        assign hmask[c][k] = hb[k] & ~i_first;
      end else begin : g_dat
        assign hmask[c][k] = hb[k];
      end
    end
  end

  for (genvar i = 0; i < T; i++) begin : g_odd
    localparam int J = 2 * i + 1;

    for (genvar c = 0; c < 3; c++) begin : g_c
      localparam code_e CC = code_e'(c);
      localparam logic [MM-1:0] STEP =
        step_pow(J, P, CC);

      logic [P-1:0][MM-1:0] term;
      logic [MM-1:0]        upd;

      for (genvar k = 0; k < P; k++) begin : g_t
        localparam logic [MM-1:0] LK =
          lane_pow(J, k, P, CC);
        assign term[k] = hmask[c][k] ? LK : '0;
      end

      // one Horner step for S_J in field CC
      always_comb begin
        upd = i_first ? '0 : gf_mul(odd_q[i], STEP, CC);
        for (int k = 0; k < P; k++) begin
          upd = upd ^ term[k];
        end
      end
    end

    assign nxt[i] =
      (ucode == C63)  ? g_c[0].upd :
      (ucode == C255) ? g_c[1].upd :
                        g_c[2].upd;
  end

  // S_2i = S_i^2, chained so S8 sees S4
  for (genvar i = 1; i <= T; i++) begin : g_sq
    logic [MM-1:0] a;
    logic [MM-1:0] y;
    if (i % 2 == 1) begin : g_src_odd
      assign a = odd_q[(i-1)/2];
    end else begin : g_src_even
      assign a = g_sq[i/2].y;
    end
    bch_gf_square u_sq (
      .code (code_q),
      .a    (a),
      .y    (y)
    );
    assign ev[i-1] = y;
  end

  // control state, beat count and code latch
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      code_q <= C63;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_n;
      err_q <= bad;
      if (start) begin
        code_q <= code_in;
        cnt    <= CW'(1);
      end else if (step) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // syndrome accumulators and zero flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      odd_q  <= '0;
      even_q <= '0;
      zero_q <= 1'b0;
    end else begin
      if (start || step) odd_q <= nxt;
      if (start) begin
        even_q <= '0;
      end else if (state == ODD) begin
        even_q <= ev;
        zero_q <= (odd_q == '0) && (ev == '0);
      end
    end
  end

  // next state
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = (beats_of(code_in) == CW'(1))
                    ? ODD : LOAD;
        end
      end
      LOAD: begin
        if (start) begin
          state_n = (beats_of(code_in) == CW'(1))
                    ? ODD : LOAD;
        end else if (bad) begin
          state_n = IDLE;
        end else if (step &&
                     (cnt + CW'(1) == beats_of(code_q))) begin
          state_n = ODD;
        end
      end
      ODD:     state_n = EVEN;
      default: state_n = IDLE;
    endcase
  end

  assign o_ready     = (state == IDLE) || (state == LOAD);
  assign o_odd_valid = (state == ODD);
  assign o_all_valid = (state == EVEN);
  assign o_zero      = (state == EVEN) && zero_q;
  assign o_code_err  = err_q;

  for (genvar i = 0; i < T; i++) begin : g_out
    assign o_synd[(2*i+1)*M-1 -: M] = M'(odd_q[i]);
    assign o_synd[(2*i+2)*M-1 -: M] = M'(even_q[i]);
  end

endmodule

// File: tb/tb_syndrome_par.sv
// Directed bench for syndrome_par with
// hand-derived syndrome vectors.
module tb_syndrome_par;

  localparam int P  = 8;
  localparam int W  = 8;
  localparam int T  = 4;
  localparam int M  = 10;
  localparam int SW = 2 * T * M;

  logic          i_clk;
  logic          i_rst;
  logic [1:0]    i_code;
  logic          i_valid;
  logic          i_first;
  logic [P*W-1:0] i_data;
  logic          o_ready;
  logic [SW-1:0] o_synd;
  logic          o_odd_valid;
  logic          o_all_valid;
  logic          o_zero;
  logic          o_code_err;

  int            n_cmp;
  int            n_bad;
  int            n_odd;
  int            n_all;
  bit            rdy_bad;
  logic [SW-1:0] odd_s;
  logic [SW-1:0] all_s;
  logic [SW-1:0] ref_s;
  logic [SW-1:0] ones_v;
  logic [SW-1:0] r1_v;
  logic          zero_s;

  syndrome_par #(
    .P (P),
    .W (W),
    .T (T),
    .M (M)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_code      (i_code),
    .i_valid     (i_valid),
    .i_first     (i_first),
    .i_data      (i_data),
    .o_ready     (o_ready),
    .o_synd      (o_synd),
    .o_odd_valid (o_odd_valid),
    .o_all_valid (o_all_valid),
    .o_zero      (o_zero),
    .o_code_err  (o_code_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_odd_valid) n_odd++;
    if (o_all_valid) n_all++;
  end

  task automatic chk(
    input string         tag,
    input logic [SW-1:0] got,
    input logic [SW-1:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [M-1:0] fld(
    input logic [SW-1:0] s,
    input int            j
  );
    return s[j*M-1 -: M];
  endfunction

  task automatic send_beats(
    input logic [1:0] code,
    input int         nb,
    input int         n,
    input int         pos,
    input bit         padbit,
    input bit         bub,
    input bit         ones
  );
    int             bb;
    int             e;
    bit             hit;
    logic [P*W-1:0] d;
    bb = (n + P - 1) / P;
    for (int b = 0; b < nb; b++) begin
      if (bub && b > 0) begin
        repeat ($urandom_range(0, 2)) begin
          i_valid = 1'b0;
          i_first = 1'b0;
          @(posedge i_clk); #1;
          if (o_ready !== 1'b1) rdy_bad = 1'b1;
        end
      end
      d = '0;
      for (int k = 0; k < P; k++) begin
        e   = bb * P - 1 - (b * P + k);
        hit = ones || (e == pos) ||
              (padbit && b == 0 && k == 0);
        d[(P-k)*W-1 -: W] = hit ? 8'h9A : 8'h65;
      end
      i_data  = d;
      i_code  = code;
      i_valid = 1'b1;
      i_first = (b == 0);
      if (o_ready !== 1'b1) rdy_bad = 1'b1;
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    i_first = 1'b0;
  endtask

  task automatic run_cw(
    input string      tag,
    input logic [1:0] code,
    input int         n,
    input int         pos,
    input bit         padbit,
    input bit         bub
  );
    send_beats(code, (n + P - 1) / P, n, pos,
               padbit, bub, 1'b0);
    chk({tag, "/oddv"}, SW'(o_odd_valid), SW'(1));
    chk({tag, "/busy"}, SW'(o_ready), SW'(0));
    odd_s = o_synd;
    @(posedge i_clk); #1;
    chk({tag, "/allv"}, SW'(o_all_valid), SW'(1));
    all_s  = o_synd;
    zero_s = o_zero;
    @(posedge i_clk); #1;
    chk({tag, "/idle"},
        SW'({o_ready, o_all_valid, o_odd_valid}),
        SW'(3'b100));
  endtask

  initial begin
    int n0;
    n_cmp   = 0;
    n_bad   = 0;
    rdy_bad = 1'b0;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_first = 1'b0;
    i_code  = 2'b00;
    i_data  = '0;
    ones_v  = '0;
    for (int j = 1; j <= 2 * T; j++) begin
      ones_v[j*M-1 -: M] = M'(1);
    end
    r1_v = {10'h00C, 10'h006, 10'h003, 10'h020,
            10'h010, 10'h008, 10'h004, 10'h002};

    #12;
    chk("rst/ready", SW'(o_ready), SW'(1));
    chk("rst/synd", o_synd, '0);
    chk("rst/flags",
        SW'({o_odd_valid, o_all_valid,
             o_zero, o_code_err}), SW'(0));
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    run_cw("z63", 2'b00, 63, -1, 1'b0, 1'b0);
    chk("z63/synd", all_s, '0);
    chk("z63/zero", SW'(zero_s), SW'(1));

    run_cw("r0_255", 2'b01, 255, 0, 1'b0, 1'b0);
    chk("r0_255/synd", all_s, ones_v);
    chk("r0_255/zero", SW'(zero_s), SW'(0));

    run_cw("r1_63", 2'b00, 63, 1, 1'b0, 1'b0);
    for (int j = 1; j < 2 * T; j += 2) begin
      chk($sformatf("r1_63/odd_S%0d", j),
          SW'(fld(odd_s, j)), SW'(fld(r1_v, j)));
    end
    chk("r1_63/all", all_s, r1_v);

    run_cw("pad63", 2'b00, 63, 62, 1'b1, 1'b0);
    chk("pad63/S1", SW'(fld(all_s, 1)), SW'(10'h021));
    chk("pad63/S2", SW'(fld(all_s, 2)), SW'(10'h031));
    chk("pad63/S3", SW'(fld(all_s, 3)), SW'(10'h039));

    run_cw("r0_1023", 2'b10, 1023, 0, 1'b0, 1'b0);
    chk("r0_1023/synd", all_s, ones_v);
    ref_s   = all_s;
    rdy_bad = 1'b0;
    run_cw("bub1023", 2'b10, 1023, 0, 1'b0, 1'b1);
    chk("bub1023/synd", all_s, ref_s);
    chk("bub1023/ready", SW'(rdy_bad), SW'(0));
    chk("bub1023/zero", SW'(zero_s), SW'(0));

    n0 = n_odd;
    send_beats(2'b10, 10, 1023, -1, 1'b0, 1'b0, 1'b1);
    run_cw("abort", 2'b00, 63, -1, 1'b0, 1'b0);
    chk("abort/pulses", SW'(n_odd - n0), SW'(1));
    chk("abort/synd", all_s, '0);
    chk("abort/zero", SW'(zero_s), SW'(1));

    n0      = n_all;
    i_valid = 1'b1;
    i_first = 1'b1;
    i_code  = 2'b11;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_first = 1'b0;
    chk("cerr/pulse", SW'(o_code_err), SW'(1));
    chk("cerr/ready", SW'(o_ready), SW'(1));
    @(posedge i_clk); #1;
    chk("cerr/end", SW'(o_code_err), SW'(0));
    @(posedge i_clk); #1;
    chk("cerr/idle",
        SW'({o_ready, o_odd_valid, n_all - n0}),
        SW'({1'b1, 1'b0, 32'd0}));

    send_beats(2'b01, 3, 255, -1, 1'b0, 1'b0, 1'b1);
    #3;
    i_rst = 1'b1;
    #1;
    chk("arst/ready", SW'(o_ready), SW'(1));
    chk("arst/synd", o_synd, '0);
    chk("arst/flags",
        SW'({o_odd_valid, o_all_valid, o_zero}), SW'(0));
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    run_cw("post_rst", 2'b00, 63, 1, 1'b0, 1'b0);
    chk("post_rst/all", all_s, r1_v);
    chk("post_rst/zero", SW'(zero_s), SW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
